icu_fetch: RTL and testbench

- Responder end of the IFU→ICU valid/ready channel.
- Accepts one {pc, snpc} fetch request at a time and issues an AXI4-Lite read (AR/R) for the instruction word.
- Forwards {pc, snpc, inst} plus an exception code to the IDU over a second valid/ready channel.
- Sits between the fetch PC generator and the decoder; honours pipeline flushes, including flushes that land while a memory read is in flight.

---
 rtl/icu_fetch.sv | 93 +++++++++
 tb/tb_icu_fetch.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/icu_fetch.sv
// icu_fetch: IFU->ICU responder that fetches one instruction word over AXI4-Lite AR/R and forwards {pc, snpc, inst, excp} to the IDU.
// Ports: clock/reset (async active-low), flush; IFU side in_valid/in_bus/in_excp/in_ready;
// AXI4-Lite read araddr/arvalid/arready, rdata/rresp/rvalid/rready; IDU side out_valid/out_bus/out_excp/out_ready;
// perf_fetch_cnt/perf_stall_cnt are live only when ICU_PERF_EN is defined, otherwise tied to 0.
module icu_fetch #(
  parameter int IN_W   = 64,
  parameter int OUT_W  = 96,
  parameter int EXCP_W = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [IN_W-1:0]   in_bus,
  input  logic              in_excp,
  output logic              in_ready,
  output logic [31:0]       araddr,
  output logic              arvalid,
  input  logic              arready,
  input  logic [31:0]       rdata,
  input  logic [1:0]        rresp,
  input  logic              rvalid,
  output logic              rready,
  output logic              out_valid,
  output logic [OUT_W-1:0]  out_bus,
  output logic [EXCP_W-1:0] out_excp,
  input  logic              out_ready,
  output logic [31:0]       perf_fetch_cnt,
  output logic [31:0]       perf_stall_cnt
);
  typedef enum logic [1:0] {IDLE, ADDR, DATA, HOLD} state_e;
  state_e             state_q;
  logic               discard_q;
  logic [31:0]        pc_q, snpc_q, inst_q;
  logic [EXCP_W-1:0]  excp_q;
  assign in_ready  = state_q == IDLE && !flush;
  assign arvalid   = state_q == ADDR;
  assign rready    = state_q == DATA;
  assign out_valid = state_q == HOLD && !flush;
  assign araddr    = pc_q;
  assign out_bus   = {pc_q, snpc_q, inst_q};
  assign out_excp  = excp_q;
  // A flush in ADDR/DATA cannot abort the AXI transaction, so discard_q marks the
  // response to be swallowed once it arrives.
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state_q   <= IDLE;
      discard_q <= 1'b0;
      pc_q      <= '0;
      snpc_q    <= '0;
      inst_q    <= '0;
      excp_q    <= '0;
    end else
      case (state_q)
        IDLE: if (in_valid && in_ready) begin
          pc_q   <= in_bus[IN_W-1 -: 32];
          snpc_q <= in_bus[31:0];
          if (in_excp) begin
            inst_q  <= '0;
            excp_q  <= EXCP_W'(1);
            state_q <= HOLD;
          end else state_q <= ADDR;
        end
        ADDR: begin
          if (flush) discard_q <= 1'b1;
          if (arready) state_q <= DATA;
        end
        DATA: if (rvalid) begin
          inst_q    <= rdata;
          excp_q    <= rresp != 2'b00 ? EXCP_W'(2) : '0;
          discard_q <= 1'b0;
          state_q   <= discard_q || flush ? IDLE : HOLD;
        end else if (flush) discard_q <= 1'b1;
        HOLD: if (flush || out_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
`ifdef ICU_PERF_EN
  logic [31:0] fetch_q, stall_q;
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      fetch_q <= '0;
      stall_q <= '0;
    end else begin
      fetch_q <= fetch_q + 32'(out_valid && out_ready);
      stall_q <= stall_q + 32'((state_q == ADDR && !arready) || (state_q == DATA && !rvalid));
    end
  assign perf_fetch_cnt = fetch_q;
  assign perf_stall_cnt = stall_q;
`else
  assign perf_fetch_cnt = '0;
  assign perf_stall_cnt = '0;
`endif
endmodule

// File: tb/tb_icu_fetch.sv
// tb_icu_fetch: directed self-checking bench for icu_fetch.
module tb_icu_fetch;
  logic        clock = 0, reset = 0, flush = 0, in_valid = 0, in_excp = 0;
  logic [63:0] in_bus = '0;
  logic        in_ready, arvalid, arready = 0, rvalid = 0, rready, out_valid, out_ready = 0;
  logic [31:0] araddr, rdata = '0, perf_fetch_cnt, perf_stall_cnt;
  logic [1:0]  rresp = '0, out_excp;
  logic [95:0] out_bus;
  int passed = 0, total = 0;

  icu_fetch dut (
    .clock(clock), .reset(reset), .flush(flush), .in_valid(in_valid), .in_bus(in_bus),
    .in_excp(in_excp), .in_ready(in_ready), .araddr(araddr), .arvalid(arvalid),
    .arready(arready), .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .out_valid(out_valid), .out_bus(out_bus), .out_excp(out_excp), .out_ready(out_ready),
    .perf_fetch_cnt(perf_fetch_cnt), .perf_stall_cnt(perf_stall_cnt)
  );

  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    #2;
    total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %0b exp 1", in_ready); else passed++;
    total++; if ({arvalid, rready, out_valid} !== 3'b000) $display("FAIL reset_handshakes got %03b exp 000", {arvalid, rready, out_valid}); else passed++;
    total++; if (out_bus !== 96'h0 || out_excp !== 2'b00) $display("FAIL reset_bus got %h/%0d exp 0/0", out_bus, out_excp); else passed++;
    total++; if (perf_fetch_cnt !== 0 || perf_stall_cnt !== 0) $display("FAIL reset_perf got %0d/%0d exp 0/0", perf_fetch_cnt, perf_stall_cnt); else passed++;
    @(negedge clock);
    reset = 1;
    tick();
  endtask

  task automatic test_basic;
    in_valid = 1; in_bus = {32'h3000_0000, 32'h3000_0004};
    arready = 1; rvalid = 1; rdata = 32'h0000_0013; rresp = 2'b00;
    #1;
    total++; if (in_ready !== 1'b1) $display("FAIL basic_accept got %0b exp 1", in_ready); else passed++;
    tick();
    in_valid = 0; #1;
    total++; if (arvalid !== 1'b1 || araddr !== 32'h3000_0000 || out_valid !== 1'b0) $display("FAIL basic_ar got arvalid=%0b araddr=%h out_valid=%0b exp 1/30000000/0", arvalid, araddr, out_valid); else passed++;
    tick();
    total++; if (rready !== 1'b1 || arvalid !== 1'b0 || out_valid !== 1'b0) $display("FAIL basic_r got rready=%0b arvalid=%0b out_valid=%0b exp 1/0/0", rready, arvalid, out_valid); else passed++;
    tick();
    total++; if (out_valid !== 1'b1 || in_ready !== 1'b0) $display("FAIL basic_hold got out_valid=%0b in_ready=%0b exp 1/0", out_valid, in_ready); else passed++;
    total++; if (out_bus !== {32'h3000_0000, 32'h3000_0004, 32'h0000_0013} || out_excp !== 2'b00) $display("FAIL basic_bus got %h/%0d exp 300000003000000400000013/0", out_bus, out_excp); else passed++;
    out_ready = 1;
    tick();
    out_ready = 0; arready = 0; rvalid = 0; #1;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL basic_done got out_valid=%0b in_ready=%0b exp 0/1", out_valid, in_ready); else passed++;
  endtask

  task automatic test_misaligned;
    in_valid = 1; in_excp = 1; in_bus = {32'h3000_0002, 32'h3000_0006};
    tick();
    in_valid = 0; in_excp = 0; #1;
    total++; if (arvalid !== 1'b0 || out_valid !== 1'b1) $display("FAIL mis_valid got arvalid=%0b out_valid=%0b exp 0/1", arvalid, out_valid); else passed++;
    total++; if (out_bus !== {32'h3000_0002, 32'h3000_0006, 32'h0} || out_excp !== 2'b01) $display("FAIL mis_bus got %h/%0d exp 300000023000000600000000/1", out_bus, out_excp); else passed++;
    out_ready = 1;
    tick();
    out_ready = 0; #1;
    total++; if (arvalid !== 1'b0 || in_ready !== 1'b1) $display("FAIL mis_done got arvalid=%0b in_ready=%0b exp 0/1", arvalid, in_ready); else passed++;
  endtask

  task automatic test_fault;
    in_valid = 1; in_bus = {32'h3000_0010, 32'h3000_0014};
    arready = 1; rvalid = 1; rdata = 32'hDEAD_BEEF; rresp = 2'b10;
    tick();
    in_valid = 0;
    tick();
    tick();
    total++; if (out_valid !== 1'b1 || out_excp !== 2'b10 || out_bus[31:0] !== 32'hDEAD_BEEF) $display("FAIL fault got out_valid=%0b excp=%0d inst=%h exp 1/2/deadbeef", out_valid, out_excp, out_bus[31:0]); else passed++;
    out_ready = 1;
    tick();
    out_ready = 0; arready = 0; rvalid = 0; rresp = 2'b00;
  endtask

  task automatic test_flush_inflight;
    in_valid = 1; in_bus = {32'h3000_0020, 32'h3000_0024}; arready = 1;
    tick();
    in_valid = 0;
    tick();
    arready = 0; flush = 1; #1;
    total++; if (rready !== 1'b1 || in_ready !== 1'b0) $display("FAIL flush_data got rready=%0b in_ready=%0b exp 1/0", rready, in_ready); else passed++;
    tick();
    flush = 0;
    for (int i = 0; i < 4; i++) begin
      total++; if (rready !== 1'b1 || out_valid !== 1'b0) $display("FAIL flush_wait%0d got rready=%0b out_valid=%0b exp 1/0", i, rready, out_valid); else passed++;
      tick();
    end
    rvalid = 1; rdata = 32'h1111_1111;
    tick();
    rvalid = 0; #1;
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || rready !== 1'b0) $display("FAIL flush_drop got in_ready=%0b out_valid=%0b rready=%0b exp 1/0/0", in_ready, out_valid, rready); else passed++;
    tick();
    total++; if (out_valid !== 1'b0 || arvalid !== 1'b0) $display("FAIL flush_quiet got out_valid=%0b arvalid=%0b exp 0/0", out_valid, arvalid); else passed++;
  endtask

  task automatic test_backpressure_flush;
    in_valid = 1; in_bus = {32'h3000_0040, 32'h3000_0044};
    arready = 1; rvalid = 1; rdata = 32'h2222_2222;
    tick();
    in_valid = 0;
    tick();
    tick();
    for (int i = 0; i < 4; i++) begin
      total++; if (out_valid !== 1'b1 || out_bus[31:0] !== 32'h2222_2222) $display("FAIL bp_hold%0d got out_valid=%0b inst=%h exp 1/22222222", i, out_valid, out_bus[31:0]); else passed++;
      tick();
    end
    flush = 1; #1;
    total++; if (out_valid !== 1'b0) $display("FAIL bp_flush got out_valid=%0b exp 0", out_valid); else passed++;
    tick();
    flush = 0;
    in_valid = 1; in_bus = {32'h3000_0100, 32'h3000_0104}; rdata = 32'h0010_0093;
    tick();
    in_valid = 0; #1;
    total++; if (arvalid !== 1'b1 || araddr !== 32'h3000_0100) $display("FAIL bp_next_ar got arvalid=%0b araddr=%h exp 1/30000100", arvalid, araddr); else passed++;
    tick();
    tick();
    total++; if (out_valid !== 1'b1 || out_bus !== {32'h3000_0100, 32'h3000_0104, 32'h0010_0093} || out_excp !== 2'b00) $display("FAIL bp_next got out_valid=%0b bus=%h excp=%0d exp 1/300001003000010400100093/0", out_valid, out_bus, out_excp); else passed++;
    out_ready = 1;
    tick();
    out_ready = 0; arready = 0; rvalid = 0;
  endtask

  task automatic test_async_reset;
    in_valid = 1; in_bus = {32'h3000_0200, 32'h3000_0204};
    tick();
    in_valid = 0; #1;
    total++; if (arvalid !== 1'b1) $display("FAIL ar_before_reset got %0b exp 1", arvalid); else passed++;
    #1 reset = 0; #1;
    total++; if (arvalid !== 1'b0 || in_ready !== 1'b1) $display("FAIL async_reset got arvalid=%0b in_ready=%0b exp 0/1", arvalid, in_ready); else passed++;
    @(negedge clock);
    reset = 1;
    tick();
  endtask

  task automatic test_perf;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1; in_bus = {32'h3000_1000 + 32'(4 * i), 32'h3000_1004 + 32'(4 * i)};
      tick();
      in_valid = 0;
      tick();
      arready = 1;
      tick();
      arready = 0;
      tick();
      rvalid = 1; rdata = 32'(i);
      tick();
      rvalid = 0; out_ready = 1;
      tick();
      out_ready = 0;
    end
    #1;
`ifdef ICU_PERF_EN
    total++; if (perf_fetch_cnt !== 32'd10 || perf_stall_cnt !== 32'd20) $display("FAIL perf got %0d/%0d exp 10/20", perf_fetch_cnt, perf_stall_cnt); else passed++;
`else
    total++; if (perf_fetch_cnt !== 32'd0 || perf_stall_cnt !== 32'd0) $display("FAIL perf_off got %0d/%0d exp 0/0", perf_fetch_cnt, perf_stall_cnt); else passed++;
`endif
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_bus !== {32'h3000_1024, 32'h3000_1028, 32'd9}) $display("FAIL perf_last got out_valid=%0b in_ready=%0b bus=%h exp 0/1/300010243000102800000009", out_valid, in_ready, out_bus); else passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_misaligned();
    test_fault();
    test_flush_inflight();
    test_backpressure_flush();
    test_async_reset();
    test_perf();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
